// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared op encoding for the add/sub accumulator
package addsub_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    ACC = 2'd2,
    CLR = 2'd3
  } op_t;

endpackage

// File: rtl/addsub_accum_if.sv
// rtl/addsub_accum_if.sv - operand/result handshake bundle for addsub_accum
// Ports: in_valid/in_ready/op/a/b/sat_en (request side),
//        out_valid/out_ready/f/ovf (result side), ovf_sticky/ovf_count (status).
interface addsub_accum_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  import addsub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             ovf;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output in_valid, op, a, b, sat_en, out_ready,
    input  in_ready, out_valid, f, ovf, ovf_sticky, ovf_count
  );

  modport slave (
    input  in_valid, op, a, b, sat_en, out_ready,
    output in_ready, out_valid, f, ovf, ovf_sticky, ovf_count
  );
endinterface

// File: rtl/addsub_core.sv
// rtl/addsub_core.sv - combinational two's complement add/subtract with saturation
// Ports: x, y operands; sub selects x - y; sat_en clamps on overflow;
//        sum result; ovf signed overflow flag.
module addsub_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             sat_en,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] raw;

  // Subtraction is x + ~y + 1; the add overflow rule on the inverted operand
  // is equivalent to the subtract rule on the original one.
  assign y_eff = sub ? ~y : y;
  assign raw   = x + y_eff + {{(WIDTH-1){1'b0}}, sub};
  assign ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (raw[WIDTH-1] != x[WIDTH-1]);

  // On overflow the true result carries the sign of x.
  always_comb begin
    sum = raw;
    if (ovf && sat_en) begin
      sum = x[WIDTH-1] ? MAX_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/addsub_accum.sv
// rtl/addsub_accum.sv - registered add/sub/accumulate unit with overflow tracking
// Ports: clk, rst (sync, active-high); bus (slave side of addsub_accum_if).
module addsub_accum
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  addsub_accum_if.slave   bus
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] f_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             sticky_q;
  logic [CNT_W-1:0] count_q;

  op_t              op_sel;
  logic             in_xfer;
  logic             is_acc;
  logic             is_clr;
  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_sum;
  logic             core_ovf;
  logic             op_ovf;

  assign op_sel       = op_t'(bus.op);
  assign is_acc       = (op_sel == ACC);
  assign is_clr       = (op_sel == CLR);

  assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign in_xfer      = bus.in_valid && bus.in_ready;

  // One adder serves all ops; ACC feeds the accumulator in place of a.
  assign core_x = is_acc ? acc_q : bus.a;
  assign core_y = is_acc ? bus.a : bus.b;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .x      (core_x),
    .y      (core_y),
    .sub    (op_sel == SUB),
    .sat_en (bus.sat_en),
    .sum    (core_sum),
    .ovf    (core_ovf)
  );

  // The adder still computes something during CLR; that never counts.
  assign op_ovf = core_ovf && !is_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      f_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      if (is_clr) begin
        acc_q    <= '0;
        f_q      <= '0;
        ovf_q    <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        f_q   <= core_sum;
        ovf_q <= op_ovf;
        if (is_acc) begin
          acc_q <= core_sum;
        end
        if (op_ovf) begin
          sticky_q <= 1'b1;
          if (count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + 1'b1;
          end
        end
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.f          = f_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.ovf_count  = count_q;

endmodule

// File: tb/tb_addsub_accum.sv
// tb/tb_addsub_accum.sv - directed-vector bench for addsub_accum
module tb_addsub_accum;
  import addsub_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  addsub_accum_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  addsub_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation with out_ready high and let it transfer.
  task automatic xfer(input op_t op, input logic [15:0] a, input logic [15:0] b, input logic sat);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.sat_en    = sat;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [15:0] f, input logic ovf);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".f"},     32'(bus.f),         32'(f));
    check({tag, ".ovf"},   32'(bus.ovf),       32'(ovf));
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.sat_en    = 1'b0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    check("rst.in_ready",  32'(bus.in_ready),   32'd0);
    check("rst.out_valid", 32'(bus.out_valid),  32'd0);
    check("rst.f",         32'(bus.f),          32'd0);
    check("rst.ovf",       32'(bus.ovf),        32'd0);
    check("rst.sticky",    32'(bus.ovf_sticky), 32'd0);
    check("rst.count",     32'(bus.ovf_count),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Overflow at the positive edge, wrap then saturate.
    xfer(ADD, 16'h7FFF, 16'h0001, 1'b0);
    check_res("add_wrap", 16'h8000, 1'b1);
    check("add_wrap.sticky", 32'(bus.ovf_sticky), 32'd1);
    check("add_wrap.count",  32'(bus.ovf_count),  32'd1);

    xfer(ADD, 16'h7FFF, 16'h0001, 1'b1);
    check_res("add_sat", 16'h7FFF, 1'b1);

    xfer(SUB, 16'h8000, 16'h0001, 1'b1);
    check_res("sub_sat", 16'h8000, 1'b1);

    xfer(SUB, 16'h8000, 16'h0001, 1'b0);
    check_res("sub_wrap", 16'h7FFF, 1'b1);
    check("sub_wrap.count", 32'(bus.ovf_count), 32'd4);

    xfer(CLR, 16'h1234, 16'h5678, 1'b0);
    check_res("clr1", 16'h0000, 1'b0);
    check("clr1.sticky", 32'(bus.ovf_sticky), 32'd0);
    check("clr1.count",  32'(bus.ovf_count),  32'd4);

    xfer(ACC, 16'h4000, 16'hFFFF, 1'b1);
    check_res("acc1", 16'h4000, 1'b0);
    check("acc1.sticky", 32'(bus.ovf_sticky), 32'd0);
    xfer(ACC, 16'h4000, 16'h0000, 1'b1);
    check_res("acc2", 16'h7FFF, 1'b1);
    xfer(ACC, 16'h4000, 16'h0000, 1'b1);
    check_res("acc3", 16'h7FFF, 1'b1);
    check("acc3.count", 32'(bus.ovf_count), 32'd6);

    xfer(CLR, 16'h0000, 16'h0000, 1'b0);
    check_res("clr2", 16'h0000, 1'b0);
    check("clr2.sticky", 32'(bus.ovf_sticky), 32'd0);
    check("clr2.count",  32'(bus.ovf_count),  32'd6);

    xfer(ADD, 16'h8000, 16'hFFFF, 1'b1);
    check_res("add_negsat", 16'h8000, 1'b1);
    check("add_negsat.count", 32'(bus.ovf_count), 32'd7);

    xfer(ADD, 16'h001B, 16'hFFFB, 1'b0);
    check_res("add_27m5", 16'h0016, 1'b0);
    check("add_27m5.sticky", 32'(bus.ovf_sticky), 32'd1);
    check("add_27m5.count",  32'(bus.ovf_count),  32'd7);

    // Output drains with no new input: valid drops, f holds.
    tick();
    check("drain.valid", 32'(bus.out_valid), 32'd0);
    check("drain.f",     32'(bus.f),         32'h0016);

    // Backpressure: result held, input refused, then no-bubble reload.
    bus.in_valid  = 1'b1;
    bus.op        = ADD;
    bus.a         = 16'h0001;
    bus.b         = 16'h0002;
    bus.sat_en    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    check_res("bp_first", 16'h0003, 1'b0);
    bus.a = 16'h0005;
    bus.b = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check_res("bp_hold", 16'h0003, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check_res("bp_next", 16'h000A, 1'b0);

    // Reset while a result is pending and acc is nonzero.
    xfer(ACC, 16'h0005, 16'h0000, 1'b0);
    check_res("acc5", 16'h0005, 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst2.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("rst2.out_valid", 32'(bus.out_valid),  32'd0);
    check("rst2.f",         32'(bus.f),          32'd0);
    check("rst2.count",     32'(bus.ovf_count),  32'd0);
    check("rst2.sticky",    32'(bus.ovf_sticky), 32'd0);
    rst = 1'b0;
    #1;
    check("rst2.in_ready_after", 32'(bus.in_ready), 32'd1);
    xfer(ACC, 16'h0001, 16'h0000, 1'b0);
    check_res("acc_after_rst", 16'h0001, 1'b0);

    // Counter saturates at its maximum.
    for (int i = 0; i < 260; i++) begin
      xfer(ADD, 16'h7FFF, 16'h7FFF, 1'b0);
    end
    check_res("cnt_sat_last", 16'hFFFE, 1'b1);
    check("cnt_sat.count", 32'(bus.ovf_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addsub_accum.md
ADDSUB_ACCUM -- requirements
Module: addsub_accum

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand, result and accumulator width in bits (min 4).
REQ-002 Parameter CNT_W, default 8, sets the overflow event counter width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready.
REQ-007 op  input  2  operation: ADD=0, SUB=1, ACC=2, CLR=3.
REQ-008 a  input  WIDTH  first operand, two's complement.
REQ-009 b  input  WIDTH  second operand, two's complement; ignored for ACC and CLR.
REQ-010 sat_en  input  1  saturate on overflow, sampled with the transfer.
REQ-011 out_valid  output  1  registered result available.
REQ-012 out_ready  input  1  consumer takes the result; transfer when out_valid && out_ready.
REQ-013 f  output  WIDTH  registered result.
REQ-014 ovf  output  1  overflow of the operation that produced f.
REQ-015 ovf_sticky  output  1  overflow seen since last CLR or reset.
REQ-016 ovf_count  output  CNT_W  number of accepted overflowing operations.

Function
REQ-017 ADD: f = a + b modulo 2^WIDTH; ovf when a, b share sign bit and the raw sum's sign differs.
REQ-018 SUB: f = a - b modulo 2^WIDTH; ovf when a, b differ in sign and the raw difference's sign differs from a.
REQ-019 ACC: acc_next = acc + a with ADD overflow rule; f = acc_next; acc updates only on input transfer.
REQ-020 CLR: acc = 0, f = 0, ovf = 0, ovf_sticky = 0; ovf_count unchanged.
REQ-021 With sat_en = 1 and ovf = 1, result (and acc for ACC) is 0x7FF..F when the true result is positive, 0x80..0 when negative; ovf still asserts.
REQ-022 Latency is exactly 1 cycle: a transfer in cycle N gives out_valid = 1 with f/ovf in cycle N+1.
REQ-023 in_ready = !rst && (!out_valid || out_ready), combinational.
REQ-024 While out_valid && !out_ready, f, ovf and out_valid hold stable and no input is accepted.
REQ-025 Output transfer and input transfer in the same cycle: out_valid stays 1, next result loads with no bubble.
REQ-026 Output transfer without input transfer: out_valid drops to 0 next cycle; f holds its last value.
REQ-027 ovf_sticky sets on any accepted operation with ovf = 1; ovf_count increments on the same event and saturates at 2^CNT_W-1.
REQ-028 CLR with a pending ovf in the same transfer is impossible (CLR never overflows); CLR takes priority over sticky set.

Reset
REQ-029 On a clk edge with rst = 1: out_valid = 0, f = 0, ovf = 0, acc = 0, ovf_sticky = 0, ovf_count = 0.
REQ-030 Reset asserted mid-operation (out_valid = 1, out_ready = 0) discards the pending result; no output transfer is reported.
REQ-031 in_ready is 0 while rst = 1; the first transfer is possible in the cycle after rst deasserts.

Structure
REQ-032 Package addsub_pkg holds the op_t enum (ADD, SUB, ACC, CLR) and the op-width constant.
REQ-033 Combinational sub-module addsub_core (WIDTH param): inputs x, y, sub, sat_en; outputs sum, ovf; instanced once, shared by ADD/SUB/ACC.
REQ-034 Top level holds acc, output register, sticky flag, counter and handshake logic only.

Verification (WIDTH = 16, CNT_W = 8)
REQ-035 ADD 0x7FFF + 0x0001, sat_en = 0 -> next cycle f = 0x8000, ovf = 1, ovf_sticky = 1, ovf_count = 1.
REQ-036 Same with sat_en = 1 -> f = 0x7FFF, ovf = 1; SUB 0x8000 - 0x0001 sat_en = 1 -> f = 0x8000, ovf = 1; sat_en = 0 -> f = 0x7FFF.
REQ-037 CLR, then ACC a = 0x4000 x3, sat_en = 1 -> f = 0x4000, 0x7FFF (ovf), 0x7FFF (ovf); ovf_count +2; CLR -> f = 0, ovf_sticky = 0, count kept.
REQ-038 out_ready = 0 for 3 cycles with result pending -> in_ready = 0, f stable; then out_ready = 1 with in_valid = 1 -> new result next cycle, no bubble.
REQ-039 27 + (-5) via ADD 0x001B + 0xFFFB -> f = 0x0016, ovf = 0, sticky unchanged.
REQ-040 rst pulsed while out_valid = 1, out_ready = 0 -> next cycle out_valid = 0, f = 0, acc = 0, ovf_count = 0; in_ready = 1 one cycle after rst falls.
